// File: rtl/timer_irq_pkg.sv
// rtl/timer_irq_pkg.sv - register map, source bit indices and APB FSM states for timer_irq_ctrl
package timer_irq_pkg;

    localparam logic [1:0] ADDR_IER     = 2'd0;
    localparam logic [1:0] ADDR_ISR     = 2'd1;
    localparam logic [1:0] ADDR_OVF_CNT = 2'd2;
    localparam logic [1:0] ADDR_UDF_CNT = 2'd3;

    localparam int BIT_OVF = 0;
    localparam int BIT_UDF = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/timer_evt_latch.sv
// rtl/timer_evt_latch.sv - per-source edge detector, sticky W1C pending bit, saturating counter
// Counter present only when TMR_IRQ_EVT_CNT_EN is defined.
module timer_evt_latch
`ifdef TMR_IRQ_EVT_CNT_EN
#(
    parameter int DATA_W = 8
)
`endif
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flag_i,
    input  logic              clr_pend_i,
`ifdef TMR_IRQ_EVT_CNT_EN
    input  logic              clr_cnt_i,
    output logic [DATA_W-1:0] cnt_o,
`endif
    output logic              pend_o
);

    logic prev_q;
    logic armed_q;
    logic pend_q;
    logic pend_d;
    logic evt;

    // armed_q masks the first cycle after reset so a flag already high is history, not an edge
    assign evt    = armed_q & flag_i & ~prev_q;
    assign pend_d = evt | (pend_q & ~clr_pend_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            prev_q  <= flag_i;
            armed_q <= 1'b1;
            pend_q  <= pend_d;
        end
    end

    assign pend_o = pend_q;

`ifdef TMR_IRQ_EVT_CNT_EN
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (evt) begin
            cnt_d = clr_cnt_i ? DATA_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
        end else if (clr_cnt_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - timer ovf/udf interrupt controller with APB slave register port
// Event counters at addresses 2/3 exist only when TMR_IRQ_EVT_CNT_EN is defined.
module timer_irq_ctrl #(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [1:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              tmr_ovf,
    input  logic              tmr_udf,
    output logic              irq
);

    import timer_irq_pkg::*;

    localparam logic [1:0] WAIT_LAST = 2'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    apb_state_e        state_q, state_d, state_cur;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic [1:0]        ier_q, ier_d;
    logic              irq_q;
    logic              access;
    logic              rsvd_set;
    logic [1:0]        pend;
    logic [1:0]        clr_pend;
    logic [DATA_W-1:0] rdata;
    logic              slverr;
`ifdef TMR_IRQ_EVT_CNT_EN
    logic [1:0]        clr_cnt;
    logic [DATA_W-1:0] ovf_cnt;
    logic [DATA_W-1:0] udf_cnt;
`endif

    // The APB setup phase is decoded straight from the bus so the first PENABLE cycle is already WAIT/ACCESS
    always_comb begin
        state_cur  = state_q;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            state_cur = SETUP;
        end
        state_d    = state_cur;
        wait_cnt_d = wait_cnt_q;
        case (state_cur)
            SETUP: begin
                wait_cnt_d = 2'd0;
                state_d    = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign access   = (state_q == ACCESS) && PSEL;
    assign rsvd_set = |PWDATA[DATA_W-1:2];

    always_comb begin
        ier_d    = ier_q;
        clr_pend = 2'b00;
        rdata    = '0;
        slverr   = 1'b0;
`ifdef TMR_IRQ_EVT_CNT_EN
        clr_cnt  = 2'b00;
`endif
        if (access) begin
            case (PADDR)
                ADDR_IER: begin
                    if (PWRITE) begin
                        ier_d  = PWDATA[1:0];
                        slverr = rsvd_set;
                    end else begin
                        rdata[1:0] = ier_q;
                    end
                end
                ADDR_ISR: begin
                    if (PWRITE) begin
                        clr_pend = PWDATA[1:0];
                        slverr   = rsvd_set;
                    end else begin
                        rdata[1:0] = pend;
                    end
                end
                default: begin
`ifdef TMR_IRQ_EVT_CNT_EN
                    if (PWRITE) begin
                        if (PWDATA != '0) begin
                            slverr = 1'b1;
                        end else if (PADDR == ADDR_OVF_CNT) begin
                            clr_cnt[BIT_OVF] = 1'b1;
                        end else begin
                            clr_cnt[BIT_UDF] = 1'b1;
                        end
                    end else begin
                        rdata = (PADDR == ADDR_OVF_CNT) ? ovf_cnt : udf_cnt;
                    end
`else
                    slverr = 1'b1;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
            ier_q      <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ier_q      <= ier_d;
            irq_q      <= |(pend & ier_q);
        end
    end

    timer_evt_latch
`ifdef TMR_IRQ_EVT_CNT_EN
        #(.DATA_W(DATA_W))
`endif
        u_ovf (
        .clk_i      (PCLK),
        .rst_ni     (PRESETn),
        .flag_i     (tmr_ovf),
        .clr_pend_i (clr_pend[BIT_OVF]),
`ifdef TMR_IRQ_EVT_CNT_EN
        .clr_cnt_i  (clr_cnt[BIT_OVF]),
        .cnt_o      (ovf_cnt),
`endif
        .pend_o     (pend[BIT_OVF])
    );

    timer_evt_latch
`ifdef TMR_IRQ_EVT_CNT_EN
        #(.DATA_W(DATA_W))
`endif
        u_udf (
        .clk_i      (PCLK),
        .rst_ni     (PRESETn),
        .flag_i     (tmr_udf),
        .clr_pend_i (clr_pend[BIT_UDF]),
`ifdef TMR_IRQ_EVT_CNT_EN
        .clr_cnt_i  (clr_cnt[BIT_UDF]),
        .cnt_o      (udf_cnt),
`endif
        .pend_o     (pend[BIT_UDF])
    );

    assign PREADY  = access;
    assign PRDATA  = rdata;
    assign PSLVERR = slverr;
    assign irq     = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - randomized self-checking bench for timer_irq_ctrl (honours TMR_IRQ_EVT_CNT_EN)
module tb_timer_irq_ctrl;

    localparam int DATA_W      = 8;
    localparam int WAIT_CYCLES = 1;
`ifdef TMR_IRQ_EVT_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [1:0]  PADDR;
    logic [7:0]  PWDATA, PRDATA;
    logic        PREADY, PSLVERR, tmr_ovf, tmr_udf, irq;

    int n_checks = 0;
    int n_errors = 0;

    bit         m_prev[2], m_pend[2], m_armed, m_irq;
    int         m_cnt[2];
    logic [1:0] m_ier;

    bit         rand_flags, c_valid, c_wr;
    logic [1:0] c_addr;
    logic [7:0] c_data;
    logic [7:0] rd;

    timer_irq_ctrl #(.DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        m_armed = 1'b0;
        m_irq   = 1'b0;
        m_ier   = 2'b00;
    endtask

    // Advances the reference by one clock using the inputs about to be sampled
    task automatic model_step();
        bit f[2];
        bit clr[2];
        bit cclr[2];
        bit ev, irq_next;
        f[0] = tmr_ovf;
        f[1] = tmr_udf;
        clr[0] = 1'b0; clr[1] = 1'b0; cclr[0] = 1'b0; cclr[1] = 1'b0;
        irq_next = (m_pend[0] && m_ier[0]) || (m_pend[1] && m_ier[1]);
        if (c_valid && c_wr) begin
            if (c_addr == 2'd0) m_ier = c_data[1:0];
            else if (c_addr == 2'd1) begin
                clr[0] = c_data[0];
                clr[1] = c_data[1];
            end else if (HAS_CNT && c_data == 8'h00) cclr[c_addr[0]] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            ev = m_armed && f[i] && !m_prev[i];
            m_pend[i] = ev || (m_pend[i] && !clr[i]);
            if (ev) m_cnt[i] = cclr[i] ? 1 : ((m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1);
            else if (cclr[i]) m_cnt[i] = 0;
            m_prev[i] = f[i];
        end
        m_armed = 1'b1;
        m_irq   = irq_next;
    endtask

    task automatic model_expect(input logic wr, input logic [1:0] a, input logic [7:0] d,
                                output logic [7:0] erd, output logic eerr);
        erd  = 8'h00;
        eerr = 1'b0;
        case (a)
            2'd0: begin erd = {6'b0, m_ier}; eerr = wr && (d[7:2] != 6'b0); end
            2'd1: begin erd = {6'b0, m_pend[1], m_pend[0]}; eerr = wr && (d[7:2] != 6'b0); end
            default: begin
                if (!HAS_CNT) eerr = 1'b1;
                else begin
                    erd  = 8'(m_cnt[a[0]]);
                    eerr = wr && (d != 8'h00);
                end
            end
        endcase
    endtask

    task automatic tick();
        if (rand_flags) begin
            tmr_ovf = 1'($urandom_range(0, 1));
            tmr_udf = 1'($urandom_range(0, 1));
        end
        model_step();
        @(posedge PCLK);
        #1;
        check("irq", irq, m_irq);
    endtask

    task automatic apb(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                       input logic edge_ovf, output logic [7:0] rdat);
        logic [7:0] erd;
        logic       eerr;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        tick();
        PENABLE = 1'b1;
        #1;
        for (int k = 0; k < WAIT_CYCLES; k++) begin
            check("pready_wait", PREADY, 1'b0);
            check("pslverr_wait", PSLVERR, 1'b0);
            check("prdata_wait", PRDATA, 8'h00);
            tick();
        end
        check("pready_access", PREADY, 1'b1);
        model_expect(wr, addr, data, erd, eerr);
        check("pslverr", PSLVERR, eerr);
        if (!wr) check("prdata", PRDATA, erd);
        rdat = PRDATA;
        c_valid = 1'b1; c_wr = wr; c_addr = addr; c_data = data;
        if (edge_ovf) tmr_ovf = 1'b1;
        tick();
        c_valid = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        check("pready_after", PREADY, 1'b0);
    endtask

    initial begin
        logic       rw;
        logic [1:0] ra;
        logic [7:0] rdat;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 2'd0; PWDATA = 8'h00;
        tmr_ovf = 1'b0; tmr_udf = 1'b0; rand_flags = 1'b0; c_valid = 1'b0; c_wr = 1'b0;
        c_addr = 2'd0; c_data = 8'h00;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_pready", PREADY, 1'b0);
        check("rst_prdata", PRDATA, 8'h00);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_irq", irq, 1'b0);
        PRESETn = 1'b1;
        for (int a = 0; a < 4; a++) apb(1'b0, 2'(a), 8'h00, 1'b0, rd);

        apb(1'b1, 2'd0, 8'h01, 1'b0, rd);
        tmr_ovf = 1'b1;
        repeat (5) tick();
        check("irq_after_ovf", irq, 1'b1);
        tmr_ovf = 1'b0;
        tick();
        apb(1'b0, 2'd1, 8'h00, 1'b0, rd);
        check("isr_ovf", rd, 8'h01);
        apb(1'b0, 2'd2, 8'h00, 1'b0, rd);
        apb(1'b1, 2'd1, 8'h01, 1'b0, rd);
        tick();
        check("irq_after_w1c", irq, 1'b0);
        apb(1'b0, 2'd1, 8'h00, 1'b0, rd);

        for (int i = 0; i < 300; i++) begin
            tmr_udf = 1'b1; tick();
            tmr_udf = 1'b0; tick();
        end
        apb(1'b0, 2'd3, 8'h00, 1'b0, rd);
        check("udf_cnt_sat", rd, HAS_CNT ? 8'hFF : 8'h00);
        apb(1'b1, 2'd3, 8'h00, 1'b0, rd);
        apb(1'b0, 2'd3, 8'h00, 1'b0, rd);
        apb(1'b1, 2'd3, 8'h05, 1'b0, rd);
        apb(1'b0, 2'd3, 8'h00, 1'b0, rd);
        apb(1'b1, 2'd1, 8'h03, 1'b0, rd);

        tick(); tick();
        apb(1'b1, 2'd1, 8'h01, 1'b1, rd);
        apb(1'b0, 2'd1, 8'h00, 1'b0, rd);
        check("set_wins", rd[0], 1'b1);
        tmr_ovf = 1'b0;

        apb(1'b1, 2'd0, 8'hFF, 1'b0, rd);
        apb(1'b0, 2'd0, 8'h00, 1'b0, rd);
        check("ier_rsvd", rd, 8'h03);

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 2'd0; PWDATA = 8'h00;
        tick();
        PENABLE = 1'b1; PSEL = 1'b0;
        #1;
        check("psel_drop_pready", PREADY, 1'b0);
        tick(); tick();
        PENABLE = 1'b0;
        apb(1'b0, 2'd0, 8'h00, 1'b0, rd);

        rand_flags = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 2'($urandom_range(0, 3));
            rdat = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            apb(rw, ra, rdat, 1'b0, rd);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_flags = 1'b0;
        tmr_ovf = 1'b0; tmr_udf = 1'b0;
        tick();

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 2'd1;
        tick();
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_pready", PREADY, 1'b0);
        check("rst_mid_prdata", PRDATA, 8'h00);
        check("rst_mid_pslverr", PSLVERR, 1'b0);
        check("rst_mid_irq", irq, 1'b0);
        model_reset();
        PSEL = 1'b0; PENABLE = 1'b0; tmr_ovf = 1'b1;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (3) tick();
        apb(1'b0, 2'd1, 8'h00, 1'b0, rd);
        check("no_pend_after_rst", rd, 8'h00);
        apb(1'b0, 2'd2, 8'h00, 1'b0, rd);
        tmr_ovf = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
Downstream consumer of the 8-bit timer's tmr_ovf/tmr_udf flags. Rising edges of either flag are captured into sticky pending bits, masked by an enable register, and combined into a single registered irq line for the CPU. Software reaches the block through its own APB slave port: enable, write-1-to-clear status, and per-source saturating event counters.

Parameters:
DATA_W, 8, APB data width and event-counter width
WAIT_CYCLES, 1, APB wait states inserted before PREADY (legal 0..3)

Ports:
PCLK  in  1  single system clock; all state on rising edge
PRESETn  in  1  asynchronous, active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1 = write, 0 = read
PADDR  in  2  register address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data, valid when PREADY=1
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid when PREADY=1
tmr_ovf  in  1  timer overflow flag (level, PCLK domain)
tmr_udf  in  1  timer underflow flag (level, PCLK domain)
irq  out  1  interrupt request, registered

Behaviour:
- Reset (PRESETn=0, async): PRDATA=0, PREADY=0, PSLVERR=0, irq=0, IER=0, ISR=0, counters=0, edge-history regs=0, FSM=IDLE.
- Register map: 0 IER (bit0 ovf_en, bit1 udf_en, rest read 0); 1 ISR (bit0 ovf_pend, bit1 udf_pend, write-1-to-clear); 2 OVF_CNT (read-only); 3 UDF_CNT (read-only).
- Edge detect: prev_x <= tmr_x each cycle; event_x = tmr_x & ~prev_x. A flag held high counts once.
- Pending: event sets bit. Event and W1C clear of the same bit in the same cycle: set wins.
- Counters: +1 per event, saturate at all-ones (0xFF stays 0xFF). Write of 0x00 clears the counter. Write of nonzero data → PSLVERR=1, no state change. Event in the same cycle as the clear: result is 1.
- irq <= |(ISR & IER[1:0]); one cycle latency after pending or enable changes.
- APB FSM: IDLE → SETUP on PSEL & ~PENABLE. SETUP → WAIT when WAIT_CYCLES>0, else → ACCESS. WAIT counts WAIT_CYCLES cycles, then → ACCESS. ACCESS drives PREADY=1 for exactly one cycle, then → IDLE. PREADY stays 0 in all other states.
- Register effects commit only in the ACCESS cycle. PRDATA and PSLVERR are valid only in that cycle; otherwise both are 0.
- PSEL dropping mid-transfer (protocol violation): FSM → IDLE, no commit.
- PSLVERR=1 conditions: nonzero write to address 2 or 3; write to IER/ISR setting any reserved bit (legal bits still commit).
- Reset asserted mid-transfer aborts it. After release, the first cycle samples a fresh edge history, so a flag already high at release produces no event.

Optional Feature:
- Macro TMR_IRQ_EVT_CNT_EN.
- Defined: OVF_CNT/UDF_CNT present, behaving as above.
- Undefined: no counter flops. Addresses 2/3 read 0; any access to them returns PSLVERR=1.

Decomposition:
- Package timer_irq_pkg: address constants (ADDR_IER=0, ADDR_ISR=1, ADDR_OVF_CNT=2, ADDR_UDF_CNT=3), bit indices BIT_OVF=0 and BIT_UDF=1, APB FSM state enum {IDLE, SETUP, WAIT, ACCESS}.
- One sub-module, timer_evt_latch, instantiated once per source. It contains the edge detector, pending bit with W1C and set-wins priority, and saturating counter.

Test Plan:
- Reset then read all four registers, WAIT_CYCLES=1 → PREADY high on the 2nd PENABLE cycle, PRDATA=0x00, PSLVERR=0, irq=0.
- IER=0x01; tmr_ovf held high 5 cycles → ISR=0x01, OVF_CNT=1, irq=1 one cycle after the pending bit sets. Write ISR=0x01 → ISR=0x00, irq=0 next cycle.
- 300 single-cycle tmr_udf pulses → UDF_CNT=0xFF. Write 0x00 to address 3 → 0x00. Write 0x05 to address 3 → PSLVERR=1, count unchanged.
- tmr_ovf rising edge in the same cycle as the ISR=0x01 write's ACCESS phase → ovf_pend remains 1.
- IER write 0xFF → PSLVERR=1, IER reads 0x03.
- PRESETn pulsed low mid-WAIT, with tmr_ovf high across the release → all outputs 0, no pending set, FSM idle. Build without TMR_IRQ_EVT_CNT_EN → reads of address 2 return 0x00 with PSLVERR=1.
